// File: rtl/mem_stage_lsu_if.sv
// Data-bus channel between the MEM-stage load/store unit and the data memory.
// The LSU drives the request half; the memory side drives ready and the load response.
interface mem_stage_lsu_if;
    logic        dbus_req_valid;
    logic        dbus_req_ready;
    logic [31:0] dbus_addr;
    logic        dbus_we;
    logic [3:0]  dbus_be;
    logic [31:0] dbus_wdata;
    logic        dbus_rsp_valid;
    logic [31:0] dbus_rdata;

    modport master (
        output dbus_req_valid, dbus_addr, dbus_we, dbus_be, dbus_wdata,
        input  dbus_req_ready, dbus_rsp_valid, dbus_rdata
    );

    modport slave (
        input  dbus_req_valid, dbus_addr, dbus_we, dbus_be, dbus_wdata,
        output dbus_req_ready, dbus_rsp_valid, dbus_rdata
    );
endinterface

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: issues one bus access per EX/MEM instruction, stalls the
// pipeline until it completes, and returns extended load data plus error pulses.
module mem_stage_lsu #(
    parameter int unsigned RSP_TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:0]     alu_result_mem,
    input  logic [31:0]     write_data_mem,
    input  logic            mem_write_mem,
    input  logic [1:0]      result_src_mem,
    input  logic [2:0]      funct3_mem,
    output logic            stall_mem,
    output logic [31:0]     read_data_mem,
    output logic            misalign_err,
    output logic            timeout_err,
    mem_stage_lsu_if.master dbus
);

    localparam logic [7:0] TMO_LIMIT = RSP_TIMEOUT[7:0];

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT_RSP,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic        we_q, we_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  off_q, off_d;
    logic [2:0]  f3_q, f3_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        mis_q, mis_d;
    logic        tmo_q, tmo_d;

    logic        access;
    logic        legal;

    // Stores only accept the signed size codes; halves need an even address, words a 4-aligned one.
    function automatic logic access_legal(input logic is_store, input logic [2:0] f3,
                                          input logic [1:0] off);
        logic ok;
        case (f3)
            3'b000:  ok = 1'b1;
            3'b001:  ok = ~off[0];
            3'b010:  ok = (off == 2'b00);
            3'b100:  ok = ~is_store;
            3'b101:  ok = ~is_store & ~off[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [3:0] lane_mask(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] m;
        case (f3[1:0])
            2'b00:   m = 4'b0001 << off;
            2'b01:   m = 4'b0011 << {off[1], 1'b0};
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] r;
        case (f3[1:0])
            2'b00:   r = {4{wd[7:0]}};
            2'b01:   r = {2{wd[15:0]}};
            default: r = wd;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [2:0] f3,
                                                input logic [1:0] off);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic [31:0]        r;
        b = 8'(word >> {off, 3'b000});
        h = 16'(word >> {off[1], 4'b0000});
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b100:  r = {24'h0, b};
            3'b101:  r = {16'h0, h};
            default: r = word;
        endcase
        return r;
    endfunction

    assign access = mem_write_mem | (result_src_mem == 2'b01);
    assign legal  = access_legal(mem_write_mem, funct3_mem, alu_result_mem[1:0]);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        we_d    = we_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        off_d   = off_q;
        f3_d    = f3_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        mis_d   = 1'b0;
        tmo_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (access) begin
                    if (legal) begin
                        addr_d  = {alu_result_mem[31:2], 2'b00};
                        we_d    = mem_write_mem;
                        be_d    = lane_mask(funct3_mem, alu_result_mem[1:0]);
                        wdata_d = store_lanes(funct3_mem, write_data_mem);
                        off_d   = alu_result_mem[1:0];
                        f3_d    = funct3_mem;
                        state_d = S_REQ;
                    end else begin
                        rdata_d = 32'h0;
                        mis_d   = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_REQ: begin
                if (dbus.dbus_req_ready) begin
                    cnt_d   = 8'd0;
                    state_d = we_q ? S_DONE : S_WAIT_RSP;
                end
            end
            S_WAIT_RSP: begin
                // A response arriving in the final allowed cycle still wins over the abort.
                if (dbus.dbus_rsp_valid) begin
                    rdata_d = load_extend(dbus.dbus_rdata, f3_q, off_q);
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_d == TMO_LIMIT) begin
                        rdata_d = 32'h0;
                        tmo_d   = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
            wdata_q <= '0;
            off_q   <= '0;
            f3_q    <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            mis_q   <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            off_q   <= off_d;
            f3_q    <= f3_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            mis_q   <= mis_d;
            tmo_q   <= tmo_d;
        end
    end

    // Stall drops in DONE so EX/MEM advances exactly once per completed access.
    assign stall_mem = reset & (((state_q == S_IDLE) & access) |
                                (state_q == S_REQ) | (state_q == S_WAIT_RSP));

    assign read_data_mem       = rdata_q;
    assign misalign_err        = mis_q;
    assign timeout_err         = tmo_q;
    assign dbus.dbus_req_valid = (state_q == S_REQ);
    assign dbus.dbus_addr      = addr_q;
    assign dbus.dbus_we        = we_q;
    assign dbus.dbus_be        = be_q;
    assign dbus.dbus_wdata     = wdata_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Randomized scoreboard bench for mem_stage_lsu with a behavioural bus responder.
module tb_mem_stage_lsu;
    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] alu_result_mem;
    logic [31:0] write_data_mem;
    logic        mem_write_mem;
    logic [1:0]  result_src_mem;
    logic [2:0]  funct3_mem;
    logic        stall_mem;
    logic [31:0] read_data_mem;
    logic        misalign_err;
    logic        timeout_err;

    mem_stage_lsu_if bus();

    mem_stage_lsu #(.RSP_TIMEOUT(TMO)) dut (
        .clk            (clk),
        .reset          (reset),
        .alu_result_mem (alu_result_mem),
        .write_data_mem (write_data_mem),
        .mem_write_mem  (mem_write_mem),
        .result_src_mem (result_src_mem),
        .funct3_mem     (funct3_mem),
        .stall_mem      (stall_mem),
        .read_data_mem  (read_data_mem),
        .misalign_err   (misalign_err),
        .timeout_err    (timeout_err),
        .dbus           (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } req_t;

    typedef struct packed {
        logic        chk_rdata;
        logic        mis;
        logic        tmo;
        logic [31:0] rdata;
        int          stall;
    } cmp_t;

    req_t        req_q[$];
    cmp_t        cmp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cur_w = 0;
    int          cur_d = 0;
    logic [31:0] cur_word = '0;
    logic        resp_busy = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail(input string name, input string why);
        checks++;
        errors++;
        $display("FAIL %s: %s", name, why);
    endtask

    // Reference: sizes in bytes, lanes by address modulo 4, extension by arithmetic.
    function automatic void model(input logic st, input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] wd, input logic [31:0] rw,
                                  input int w, input int d,
                                  output logic legal, output req_t rq, output cmp_t c);
        int          size;
        int          off;
        logic [31:0] v;
        logic [31:0] mask;
        size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        off   = int'(a[1:0]);
        legal = !(f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) && !(st && f3[2]) && (off % size == 0);
        rq.addr = a & 32'hFFFF_FFFC;
        rq.we   = st;
        rq.be   = 4'(((1 << size) - 1) << off);
        for (int i = 0; i < 4; i++) rq.wdata[8*i +: 8] = wd[8*(i % size) +: 8];
        mask = (size == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * size)) - 32'h1);
        v    = (rw >> (8 * off)) & mask;
        if (!f3[2] && size < 4 && v[8*size-1]) v = v | ~mask;
        c.chk_rdata = !st || !legal;
        c.mis       = !legal;
        c.tmo       = legal && !st && (d >= TMO);
        c.rdata     = (!legal || c.tmo) ? 32'h0 : v;
        if (!legal)  c.stall = 1;
        else if (st) c.stall = 2 + w;
        else         c.stall = 2 + w + (((d + 1) < TMO) ? (d + 1) : TMO);
    endfunction

    task automatic idle_inputs();
        logic [1:0] rs;
        rs = 2'($urandom_range(0, 2));
        mem_write_mem  = 1'b0;
        result_src_mem = (rs == 2'd1) ? 2'd3 : rs;
        funct3_mem     = 3'($urandom);
        alu_result_mem = $urandom;
        write_data_mem = $urandom;
    endtask

    // Memory responder: holds ready low cur_w cycles, answers loads cur_d cycles after handshake.
    initial begin
        bus.dbus_req_ready = 1'b0;
        bus.dbus_rsp_valid = 1'b0;
        bus.dbus_rdata     = '0;
        forever begin
            @(posedge clk); #2;
            if (reset === 1'b1 && bus.dbus_req_valid === 1'b1) begin
                resp_busy = 1'b1;
                repeat (cur_w) begin @(posedge clk); #2; end
                bus.dbus_req_ready = 1'b1;
                @(posedge clk); #2;
                bus.dbus_req_ready = 1'b0;
                if (!bus.dbus_we) begin
                    repeat (cur_d) begin @(posedge clk); #2; end
                    bus.dbus_rsp_valid = 1'b1;
                    bus.dbus_rdata     = cur_word;
                    @(posedge clk); #2;
                    bus.dbus_rsp_valid = 1'b0;
                    bus.dbus_rdata     = $urandom;
                end
                resp_busy = 1'b0;
            end
        end
    end

    // Monitor: checks requests at handshake and completions when stall drops on a live access.
    logic hold = 1'b0;
    req_t held;
    int   stall_cnt = 0;
    always @(negedge clk) begin
        logic acc;
        req_t r;
        cmp_t c;
        acc = mem_write_mem | (result_src_mem == 2'b01);
        if (reset !== 1'b1) begin
            hold      = 1'b0;
            stall_cnt = 0;
        end else begin
            if (hold) begin
                chk("req_hold_valid", 32'(bus.dbus_req_valid), 32'd1);
                chk("req_hold_addr", bus.dbus_addr, held.addr);
                chk("req_hold_we", 32'(bus.dbus_we), 32'(held.we));
                chk("req_hold_be", 32'(bus.dbus_be), 32'(held.be));
                chk("req_hold_wdata", bus.dbus_wdata, held.wdata);
            end
            hold = 1'b0;
            if (bus.dbus_req_valid) begin
                if (!bus.dbus_req_ready) begin
                    hold       = 1'b1;
                    held.addr  = bus.dbus_addr;
                    held.we    = bus.dbus_we;
                    held.be    = bus.dbus_be;
                    held.wdata = bus.dbus_wdata;
                end else if (req_q.size() == 0) begin
                    fail("req_unexpected", "bus request with none expected");
                end else begin
                    r = req_q.pop_front();
                    chk("req_addr", bus.dbus_addr, r.addr);
                    chk("req_we", 32'(bus.dbus_we), 32'(r.we));
                    chk("req_be", 32'(bus.dbus_be), 32'(r.be));
                    if (r.we) chk("req_wdata", bus.dbus_wdata, r.wdata);
                end
            end
            if (stall_mem) stall_cnt++;
            if (acc && !stall_mem) begin
                if (cmp_q.size() == 0) begin
                    fail("done_unexpected", "completion with none expected");
                end else begin
                    c = cmp_q.pop_front();
                    chk("misalign_err", 32'(misalign_err), 32'(c.mis));
                    chk("timeout_err", 32'(timeout_err), 32'(c.tmo));
                    chk("stall_cycles", 32'(stall_cnt), 32'(c.stall));
                    if (c.chk_rdata) chk("read_data", read_data_mem, c.rdata);
                end
                stall_cnt = 0;
            end else begin
                chk("err_outside_done", {30'h0, misalign_err, timeout_err}, 32'h0);
                if (!acc) chk("stall_no_access", 32'(stall_mem), 32'h0);
            end
        end
    end

    // Called #1 after a posedge; returns #1 after a posedge with the bus quiet.
    task automatic do_access(input logic st, input logic [1:0] rsrc, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rw,
                             input int w, input int d);
        logic legal;
        req_t rq;
        cmp_t c;
        int   n;
        model(st, f3, a, wd, rw, w, d, legal, rq, c);
        if (legal) req_q.push_back(rq);
        cmp_q.push_back(c);
        cur_w          = w;
        cur_d          = d;
        cur_word       = rw;
        mem_write_mem  = st;
        result_src_mem = st ? rsrc : 2'b01;
        funct3_mem     = f3;
        alu_result_mem = a;
        write_data_mem = wd;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (stall_mem && n < 60);
        if (stall_mem) fail("done_wait", "stall never released");
        @(posedge clk); #1;
        idle_inputs();
        n = 0;
        while (resp_busy && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        if (resp_busy) fail("responder_wait", "responder never went idle");
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_valid"}, 32'(bus.dbus_req_valid), 32'h0);
        chk({tag, "_addr"}, bus.dbus_addr, 32'h0);
        chk({tag, "_we"}, 32'(bus.dbus_we), 32'h0);
        chk({tag, "_be"}, 32'(bus.dbus_be), 32'h0);
        chk({tag, "_wdata"}, bus.dbus_wdata, 32'h0);
        chk({tag, "_read_data"}, read_data_mem, 32'h0);
        chk({tag, "_errs"}, {30'h0, misalign_err, timeout_err}, 32'h0);
        chk({tag, "_stall"}, 32'(stall_mem), 32'h0);
    endtask

    task automatic reset_during_wait();
        req_t rq;
        cmp_t c;
        logic legal;
        int   n;
        model(1'b0, 3'b010, 32'h0000_0500, 32'h0, 32'h1234_5678, 0, 20, legal, rq, c);
        req_q.push_back(rq);
        cur_w          = 0;
        cur_d          = 20;
        cur_word       = 32'h1234_5678;
        mem_write_mem  = 1'b0;
        result_src_mem = 2'b01;
        funct3_mem     = 3'b010;
        alu_result_mem = 32'h0000_0500;
        write_data_mem = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        idle_inputs();
        #1;
        chk("rst_mid_stall", 32'(stall_mem), 32'h0);
        @(posedge clk); #1;
        check_reset_outputs("rst_mid");
        reset = 1'b1;
        n = 0;
        while (resp_busy && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        if (resp_busy) fail("rst_responder_wait", "responder never went idle");
        @(posedge clk); #1;
        chk("rst_late_rsp_ignored", read_data_mem, 32'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  legal_f3 [5];
        logic        st;
        logic [2:0]  f3;
        logic [31:0] a;
        legal_f3[0] = 3'b000; legal_f3[1] = 3'b001; legal_f3[2] = 3'b010;
        legal_f3[3] = 3'b100; legal_f3[4] = 3'b101;
        reset = 1'b0;
        idle_inputs();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("init");
        reset = 1'b1;
        @(posedge clk); #1;

        do_access(1'b1, 2'b00, 3'b010, 32'h0000_0100, 32'hCAFE_BABE, 32'h0, 0, 0);
        do_access(1'b1, 2'b00, 3'b000, 32'h0000_0203, 32'h0000_00A5, 32'h0, 3, 0);
        do_access(1'b0, 2'b01, 3'b000, 32'h0000_0301, 32'h0, 32'h0000_8000, 0, 0);
        do_access(1'b0, 2'b01, 3'b100, 32'h0000_0301, 32'h0, 32'h0000_8000, 0, 0);
        do_access(1'b0, 2'b01, 3'b001, 32'h0000_0302, 32'h0, 32'hF00D_0000, 0, 0);
        do_access(1'b0, 2'b01, 3'b010, 32'h0000_0102, 32'h0, 32'h0, 0, 0);
        do_access(1'b1, 2'b01, 3'b001, 32'h0000_0602, 32'h1234_BEEF, 32'h0, 1, 0);
        do_access(1'b0, 2'b01, 3'b010, 32'h0000_0400, 32'h0, 32'hDEAD_BEEF, 0, TMO + 2);
        do_access(1'b0, 2'b01, 3'b010, 32'h0000_0404, 32'h0, 32'h0BAD_F00D, 2, TMO - 1);
        reset_during_wait();
        @(posedge clk); #1;

        for (int i = 0; i < 200; i++) begin
            st = 1'($urandom_range(0, 1));
            f3 = ($urandom_range(0, 3) != 0) ? legal_f3[$urandom_range(0, 4)] : 3'($urandom);
            a  = $urandom;
            if ($urandom_range(0, 2) == 0) a[1:0] = 2'b00;
            do_access(st, 2'($urandom), f3, a, $urandom, $urandom,
                      $urandom_range(0, 3), $urandom_range(0, TMO + 2));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #0;
        end

        repeat (5) @(posedge clk);
        #1;
        chk("req_queue_drained", 32'(req_q.size()), 32'h0);
        chk("cmp_queue_drained", 32'(cmp_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
